// File: rtl/demux_rr.sv
// One-to-NUM_CH demultiplexer with one-entry holding register per channel and
// round-robin or directed routing. Define DEMUX_RR_STATS_EN to add per-channel accept counters.
module demux_rr #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned SEL_W  = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic                     valid_in,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     ready_in,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel_in,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic [NUM_CH-1:0]        valid_out,
  input  logic [NUM_CH-1:0]        pop,
  output logic [SEL_W-1:0]         rr_ptr
`ifdef DEMUX_RR_STATS_EN
  ,
  output logic [NUM_CH*8-1:0]      cnt_out
`endif
);

  localparam logic [SEL_W:0]   NumChW = (SEL_W+1)'(NUM_CH);
  localparam logic [SEL_W-1:0] LastCh = SEL_W'(NUM_CH - 1);

  logic [NUM_CH-1:0][DATA_W-1:0] data_q, data_d;
  logic [NUM_CH-1:0]             valid_q, valid_d;
  logic [SEL_W-1:0]              rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]              tgt;
  logic                          sel_ok;
  logic                          tgt_busy;
  logic                          accept;
  logic [NUM_CH-1:0]             load;

  // Target selection and acceptance; an out-of-range directed index never accepts.
  always_comb begin
    tgt      = mode ? sel_in : rr_ptr_q;
    sel_ok   = ~mode | ({1'b0, sel_in} < NumChW);
    tgt_busy = 1'b0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (tgt == SEL_W'(i)) tgt_busy = valid_q[i] & ~pop[i];
    end
    ready_in = sel_ok & ~tgt_busy;
    accept   = valid_in & ready_in;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      load[i] = accept & (tgt == SEL_W'(i));
    end
  end

  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    rr_ptr_d = rr_ptr_q;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (load[i]) begin
        valid_d[i] = 1'b1;
        data_d[i]  = data_in;
      end else if (pop[i] && valid_q[i]) begin
        valid_d[i] = 1'b0;
        data_d[i]  = '0;
      end
    end
    if (!mode && accept) begin
      rr_ptr_d = (rr_ptr_q == LastCh) ? '0 : rr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      valid_q  <= '0;
      data_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign rr_ptr    = rr_ptr_q;

`ifdef DEMUX_RR_STATS_EN
  logic [NUM_CH-1:0][7:0] cnt_q;

  // Saturating accept counters, one per channel.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (load[i] && (cnt_q[i] != 8'hFF)) cnt_q[i] <= cnt_q[i] + 8'd1;
      end
    end
  end

  assign cnt_out = cnt_q;
`endif

endmodule

// File: tb/tb_demux_rr.sv
// Directed self-checking bench for demux_rr: a 2-channel and a 4-channel instance
// (the latter with a widened index so out-of-range directed selects can be driven).
module tb_demux_rr;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 2-channel instance
  logic       valid2 = 1'b0;
  logic [3:0] data2 = '0;
  logic       ready2;
  logic       mode2 = 1'b0;
  logic       sel2 = 1'b0;
  logic [7:0] dout2;
  logic [1:0] vout2;
  logic [1:0] pop2 = '0;
  logic       rr2;

  // 4-channel instance
  logic        valid4 = 1'b0;
  logic [3:0]  data4 = '0;
  logic        ready4;
  logic        mode4 = 1'b0;
  logic [2:0]  sel4 = '0;
  logic [15:0] dout4;
  logic [3:0]  vout4;
  logic [3:0]  pop4 = '0;
  logic [2:0]  rr4;
`ifdef DEMUX_RR_STATS_EN
  logic [15:0] cnt2;
  logic [31:0] cnt4;
`endif

  demux_rr #(.DATA_W(4), .NUM_CH(2)) dut2 (
    .clk(clk), .reset_L(reset_L), .valid_in(valid2), .data_in(data2), .ready_in(ready2),
    .mode(mode2), .sel_in(sel2), .data_out(dout2), .valid_out(vout2), .pop(pop2),
    .rr_ptr(rr2)
`ifdef DEMUX_RR_STATS_EN
    , .cnt_out(cnt2)
`endif
  );

  demux_rr #(.DATA_W(4), .NUM_CH(4), .SEL_W(3)) dut4 (
    .clk(clk), .reset_L(reset_L), .valid_in(valid4), .data_in(data4), .ready_in(ready4),
    .mode(mode4), .sel_in(sel4), .data_out(dout4), .valid_out(vout4), .pop(pop4),
    .rr_ptr(rr4)
`ifdef DEMUX_RR_STATS_EN
    , .cnt_out(cnt4)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_vout2", 64'(vout2), 64'h0);
    chk("rst_dout2", 64'(dout2), 64'h0);
    chk("rst_rr2",   64'(rr2),   64'h0);
    chk("rst_vout4", 64'(vout4), 64'h0);
    chk("rst_dout4", 64'(dout4), 64'h0);
    chk("rst_rr4",   64'(rr4),   64'h0);
    reset_L = 1'b1;

    // Round-robin on 2 channels with both pops held
    pop2 = 2'b11;
    valid2 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data2 = 4'(k + 1);
      #1;
      chk("rr2_ptr_pre", 64'(rr2), 64'(k % 2));
      chk("rr2_ready", 64'(ready2), 64'h1);
      @(negedge clk);
      chk("rr2_vout", 64'(vout2), 64'(1 << (k % 2)));
      chk("rr2_dout", 64'(dout2), 64'((k + 1) << (4 * (k % 2))));
    end
    valid2 = 1'b0;
    chk("rr2_ptr_end", 64'(rr2), 64'h0);

    // Fill 4 channels with no pops
    valid4 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data4 = 4'(k + 5);
      #1;
      chk("fill_ready", 64'(ready4), 64'h1);
      chk("fill_rr", 64'(rr4), 64'(k));
      @(negedge clk);
    end
    chk("fill_vout", 64'(vout4), 64'hF);
    chk("fill_dout", 64'(dout4), 64'h8765);
    data4 = 4'h9;
    #1;
    chk("stall_ready", 64'(ready4), 64'h0);
    chk("stall_rr", 64'(rr4), 64'h0);
    @(negedge clk);
    chk("stall_dout", 64'(dout4), 64'h8765);
    chk("stall_rr2", 64'(rr4), 64'h0);
    pop4 = 4'b0001;
    #1;
    chk("popfree_ready", 64'(ready4), 64'h1);
    @(negedge clk);
    pop4 = '0;
    valid4 = 1'b0;
    chk("b2b_vout", 64'(vout4), 64'hF);
    chk("b2b_dout", 64'(dout4), 64'h8769);
    chk("b2b_rr", 64'(rr4), 64'h1);

    // Directed replace into full ch2 with simultaneous pop
    mode4 = 1'b1;
    sel4 = 3'd2;
    data4 = 4'hA;
    valid4 = 1'b1;
    pop4 = 4'b0100;
    #1;
    chk("dir_ready", 64'(ready4), 64'h1);
    @(negedge clk);
    valid4 = 1'b0;
    pop4 = 4'b1111;
    chk("dir_vout", 64'(vout4), 64'hF);
    chk("dir_dout", 64'(dout4), 64'h8A69);
    chk("dir_rr_hold", 64'(rr4), 64'h1);
    @(negedge clk);
    pop4 = '0;
    chk("popall_vout", 64'(vout4), 64'h0);
    chk("popall_dout", 64'(dout4), 64'h0);

    // Out-of-range directed select
    sel4 = 3'd5;
    data4 = 4'hF;
    valid4 = 1'b1;
    #1;
    chk("oor_ready", 64'(ready4), 64'h0);
    @(negedge clk);
    chk("oor_vout", 64'(vout4), 64'h0);
    chk("oor_dout", 64'(dout4), 64'h0);

    // Directed words do not move rr_ptr; next RR word goes to ch1
    sel4 = 3'd3;
    data4 = 4'hB;
    @(negedge clk);
    chk("ms_rr_a", 64'(rr4), 64'h1);
    chk("ms_dout_a", 64'(dout4), 64'hB000);
    #1;
    chk("ms_busy_ready", 64'(ready4), 64'h0);
    sel4 = 3'd0;
    data4 = 4'hC;
    @(negedge clk);
    chk("ms_rr_b", 64'(rr4), 64'h1);
    chk("ms_vout_b", 64'(vout4), 64'h9);
    mode4 = 1'b0;
    data4 = 4'hD;
    #1;
    chk("ms_rr_c", 64'(rr4), 64'h1);
    @(negedge clk);
    valid4 = 1'b0;
    chk("ms_vout_c", 64'(vout4), 64'hB);
    chk("ms_dout_c", 64'(dout4), 64'hB0DC);
    chk("ms_rr_d", 64'(rr4), 64'h2);

    // Asynchronous reset between edges
    #2;
    reset_L = 1'b0;
    #1;
    chk("arst_vout", 64'(vout4), 64'h0);
    chk("arst_dout", 64'(dout4), 64'h0);
    chk("arst_rr", 64'(rr4), 64'h0);
    valid4 = 1'b1;
    data4 = 4'hE;
    @(negedge clk);
    chk("rst_noacc", 64'(vout4), 64'h0);
    reset_L = 1'b1;
    #1;
    chk("post_rst_rr", 64'(rr4), 64'h0);
    @(negedge clk);
    valid4 = 1'b0;
    chk("post_rst_vout", 64'(vout4), 64'h1);
    chk("post_rst_dout", 64'(dout4), 64'h000E);

`ifdef DEMUX_RR_STATS_EN
    chk("cnt_one", 64'(cnt4), 64'h1);
    mode4 = 1'b1;
    sel4 = 3'd0;
    pop4 = 4'b0001;
    valid4 = 1'b1;
    for (int k = 0; k < 300; k++) @(negedge clk);
    valid4 = 1'b0;
    pop4 = '0;
    chk("cnt_sat", 64'(cnt4), 64'h0000_00FF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
